micro_sequencer: RTL and testbench

Microprogram sequencer that drives the address port of the control ROM (6-bit address, 20-bit microword) and turns each fetched microword into a registered control vector for the datapath. It owns the micro-PC, a small return stack, and the sequencing logic: next, jump, conditional branch, call/return, wait-on-condition and end. It sits between the instruction decoder, which supplies a dispatch address and a start strobe, and the ROM/datapath pair.

---
 rtl/micro_sequencer.sv | 139 +++++++++++++
 tb/tb_micro_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC and the return stack, and registers the
// control field of each fetched microword for the datapath.
module micro_sequencer #(
    parameter int WIDTH_ADD   = 6,
    parameter int WIDTH_DATA  = 20,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH_ADD-1:0]  dispatch_addr,
    input  logic [3:0]            cond,
    input  logic                  clear,
    output logic [WIDTH_ADD-1:0]  rom_addr,
    input  logic [WIDTH_DATA-1:0] rom_data,
    output logic [8:0]            ctrl,
    output logic                  ctrl_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
    typedef enum logic [2:0] {
        OP_NEXT, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET, OP_END, OP_WAIT, OP_SPARE
    } op_t;

    state_t               state, state_next;
    logic [WIDTH_ADD-1:0] upc, upc_next, upc_inc, target, stack_top;
    logic [SP_W-1:0]      sp, sp_next;
    logic [8:0]           ctrl_next;
    logic                 valid_next, done_next, push, c;
    logic [1:0]           csel;
    op_t                  op;

    // Entries beyond STACK_DEPTH exist only so every sp value is a legal index.
    logic [WIDTH_ADD-1:0] stack [2**SP_W];

    assign op        = op_t'(rom_data[WIDTH_DATA-1 -: 3]);
    assign csel      = rom_data[WIDTH_DATA-4 -: 2];
    assign target    = rom_data[9 +: WIDTH_ADD];
    assign c         = cond[csel];
    assign upc_inc   = upc + WIDTH_ADD'(1);
    assign stack_top = stack[sp - SP_W'(1)];

    assign rom_addr = upc;
    assign busy     = (state == RUN);
    assign err      = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            upc        <= '0;
            sp         <= '0;
            ctrl       <= '0;
            ctrl_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            upc        <= upc_next;
            sp         <= sp_next;
            ctrl       <= ctrl_next;
            ctrl_valid <= valid_next;
            done       <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[sp] <= upc_inc;
    end

    always_comb begin
        state_next = state;
        upc_next   = upc;
        sp_next    = sp;
        ctrl_next  = '0;
        valid_next = 1'b0;
        done_next  = 1'b0;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                upc_next = '0;
                if (start) begin
                    upc_next   = dispatch_addr;
                    sp_next    = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                ctrl_next  = rom_data[8:0];
                valid_next = 1'b1;
                unique case (op)
                    OP_JUMP:   upc_next = target;
                    OP_BRANCH: upc_next = c ? target : upc_inc;
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            state_next = ERR;
                        end else begin
                            push     = 1'b1;
                            sp_next  = sp + SP_W'(1);
                            upc_next = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            state_next = ERR;
                        end else begin
                            upc_next = stack_top;
                            sp_next  = sp - SP_W'(1);
                        end
                    end
                    OP_WAIT: upc_next = c ? upc_inc : upc;
                    OP_END: begin
                        done_next  = 1'b1;
                        upc_next   = '0;
                        state_next = IDLE;
                    end
                    default: upc_next = upc_inc;
                endcase
                // A faulting CALL/RET never reaches the datapath.
                if (state_next == ERR) begin
                    upc_next   = '0;
                    sp_next    = '0;
                    ctrl_next  = '0;
                    valid_next = 1'b0;
                end
            end
            ERR: begin
                upc_next = '0;
                sp_next  = '0;
                if (clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed programs plus random ROM contents,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  dispatch_addr;
    logic [3:0]  cond;
    logic        clear;
    logic [5:0]  rom_addr;
    logic [19:0] rom_data;
    logic [8:0]  ctrl;
    logic        ctrl_valid, busy, done, err;

    logic [19:0] rom [64];
    assign rom_data = rom[rom_addr];

    micro_sequencer #(.WIDTH_ADD(6), .WIDTH_DATA(20), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dispatch_addr(dispatch_addr),
        .cond(cond), .clear(clear), .rom_addr(rom_addr), .rom_data(rom_data),
        .ctrl(ctrl), .ctrl_valid(ctrl_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;

    // Behavioural model: program counter, flags, and a queue as the return stack.
    bit       m_running, m_errored, e_valid, e_done;
    int       m_pc;
    int       m_stack[$];
    int       e_ctrl;
    string    phase;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [19:0] mw(input int op, input int cs, input int tgt, input int cv);
        return {op[2:0], cs[1:0], tgt[5:0], cv[8:0]};
    endfunction

    task automatic modelReset();
        m_running = 0; m_errored = 0; m_pc = 0; e_ctrl = 0; e_valid = 0; e_done = 0;
        m_stack.delete();
    endtask

    task automatic modelFault();
        m_running = 0; m_errored = 1; m_pc = 0; e_ctrl = 0; e_valid = 0;
        m_stack.delete();
    endtask

    task automatic modelStep();
        logic [19:0] w;
        int op, tgt, nxt;
        bit cv;
        e_ctrl = 0; e_valid = 0; e_done = 0;
        if (m_errored) begin
            m_pc = 0;
            m_stack.delete();
            if (clear) m_errored = 0;
        end else if (!m_running) begin
            m_pc = 0;
            if (start) begin
                m_pc = dispatch_addr;
                m_stack.delete();
                m_running = 1;
            end
        end else begin
            w      = rom[m_pc];
            op     = w[19:17];
            tgt    = w[14:9];
            cv     = cond[w[16:15]];
            nxt    = (m_pc + 1) % 64;
            e_ctrl = w[8:0];
            e_valid = 1;
            case (op)
                1: m_pc = tgt;
                2: m_pc = cv ? tgt : nxt;
                3: if (m_stack.size() == 4) modelFault();
                   else begin m_stack.push_back(nxt); m_pc = tgt; end
                4: if (m_stack.size() == 0) modelFault();
                   else m_pc = m_stack.pop_back();
                5: begin e_done = 1; m_pc = 0; m_running = 0; end
                6: if (cv) m_pc = nxt;
                default: m_pc = nxt;
            endcase
        end
    endtask

    task automatic checkAll();
        checkOutput({phase, " rom_addr"}, 32'(rom_addr), 32'(m_pc));
        checkOutput({phase, " ctrl"}, 32'(ctrl), 32'(e_ctrl));
        checkOutput({phase, " ctrl_valid"}, 32'(ctrl_valid), 32'(e_valid));
        checkOutput({phase, " busy"}, 32'(busy), 32'(m_running));
        checkOutput({phase, " done"}, 32'(done), 32'(e_done));
        checkOutput({phase, " err"}, 32'(err), 32'(m_errored));
    endtask

    task automatic applyStimulus(input bit s, input logic [5:0] d, input logic [3:0] c, input bit cl);
        start = s; dispatch_addr = d; cond = c; clear = cl;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic runToIdle(input int max_cycles);
        for (int i = 0; i < max_cycles && m_running; i++)
            applyStimulus(0, 6'($urandom), 4'($urandom), 0);
    endtask

    task automatic fillEnd();
        for (int i = 0; i < 64; i++) rom[i] = mw(5, 0, 0, 9'h100 + i);
    endtask

    initial begin
        rst_n = 0; start = 0; dispatch_addr = 0; cond = 0; clear = 0;
        fillEnd();
        modelReset();
        phase = "reset";
        #1;
        checkAll();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Linear program
        phase = "linear";
        rom[5] = mw(0, 0, 0, 9'h001);
        rom[6] = mw(0, 0, 0, 9'h002);
        rom[7] = mw(5, 0, 0, 9'h004);
        applyStimulus(1, 5, 0, 0);
        checkOutput("linear first addr", 32'(rom_addr), 5);
        applyStimulus(0, 0, 0, 0);
        checkOutput("linear ctrl1", 32'(ctrl), 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("linear end ctrl", 32'(ctrl), 4);
        checkOutput("linear done", 32'(done), 1);
        applyStimulus(0, 0, 0, 0);

        // Branch taken and not taken
        phase = "branch";
        fillEnd();
        rom[10] = mw(2, 2, 20, 9'h033);
        applyStimulus(1, 10, 0, 0);
        applyStimulus(0, 0, 4'b0100, 0);
        checkOutput("branch taken", 32'(rom_addr), 20);
        runToIdle(10);
        applyStimulus(1, 10, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0);
        checkOutput("branch not taken", 32'(rom_addr), 11);
        runToIdle(10);

        // Nested call/return
        phase = "callret";
        fillEnd();
        rom[0]  = mw(3, 0, 30, 9'h010);
        rom[30] = mw(3, 0, 40, 9'h011);
        rom[40] = mw(4, 0, 0, 9'h012);
        rom[31] = mw(4, 0, 0, 9'h013);
        rom[1]  = mw(5, 0, 0, 9'h014);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("callret return addr", 32'(rom_addr), 31);
        applyStimulus(0, 0, 0, 0);
        checkOutput("callret final addr", 32'(rom_addr), 1);
        runToIdle(5);
        checkOutput("callret no err", 32'(err), 0);

        // Stack overflow, recovery, then RET on an empty stack
        phase = "overflow";
        fillEnd();
        for (int i = 20; i < 25; i++) rom[i] = mw(3, 0, i + 1, 9'h020 + i);
        applyStimulus(1, 20, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("overflow err", 32'(err), 1);
        applyStimulus(1, 5, 0, 0);
        checkOutput("err ignores start", 32'(busy), 0);
        applyStimulus(0, 0, 0, 1);
        rom[5] = mw(0, 0, 0, 9'h001);
        rom[6] = mw(5, 0, 0, 9'h002);
        applyStimulus(1, 5, 0, 0);
        runToIdle(5);
        rom[33] = mw(4, 0, 0, 9'h0AA);
        applyStimulus(1, 33, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ret empty err", 32'(err), 1);
        applyStimulus(0, 0, 0, 1);

        // Wait with wrap from 63 to 0
        phase = "wait";
        fillEnd();
        rom[63] = mw(6, 0, 0, 9'h0CC);
        applyStimulus(1, 63, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b1110, 0);
        checkOutput("wait held", 32'(rom_addr), 63);
        applyStimulus(0, 0, 4'b0001, 0);
        checkOutput("wait wrap", 32'(rom_addr), 0);
        runToIdle(5);

        // Reset in the middle of a run
        phase = "midreset";
        for (int i = 10; i < 13; i++) rom[i] = mw(0, 0, 0, i);
        applyStimulus(1, 10, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        #2 rst_n = 0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1 rst_n = 1;
        applyStimulus(1, 10, 0, 0);
        runToIdle(10);

        // Random ROM contents and random control inputs
        phase = "random";
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) rom[i] = 20'($urandom);
            for (int n = 0; n < 800; n++)
                applyStimulus($urandom_range(0, 3) == 0, 6'($urandom), 4'($urandom),
                              $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
